// File: rtl/sent_pkg.sv
// Shared SENT scheduler types: FSM state encoding, channel format codes, latched message record.
// Pure definitions, no logic.
// Imported by the scheduler and its arbiter.
package sent_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_START = 3'd2,
        ST_BUSY  = 3'd3,
        ST_GAP   = 3'd4
    } sched_state_t;

    localparam logic FMT_SERIAL   = 1'b0;
    localparam logic FMT_ENHANCED = 1'b1;

    typedef struct packed {
        logic        fmt;
        logic        cfg;
        logic [7:0]  id;
        logic [15:0] data;
    } sent_msg_t;

    // Counter width able to hold max_val; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sent_rr_arb2.sv
// Two-requester arbiter: round-robin against last owner, or fixed A-first priority.
// Latency: combinational.
// Backpressure: none; grant is zero when nobody requests.
module sent_rr_arb2
    import sent_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_owner_i,
    input  logic       fixed_prio_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (fixed_prio_i) begin
            if (req_i[0]) begin
                gnt_o = 2'b01;
            end else if (req_i[1]) begin
                gnt_o = 2'b10;
            end
        end else begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                // Contention: the requester that did not own the last message wins.
                2'b11:   gnt_o = last_owner_i ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/sent_tx_scheduler.sv
// Schedules messages from requesters A/B onto one SENT transmitter; SENT_SCHED_FIXED_PRIO_EN selects fixed priority.
// Latency: request to ack 1 cycle, to enable 2 cycles; done 1 cycle after tx_idle_i rises or on timeout.
// Backpressure: requests are held until ack; new requests wait through BUSY and GAP_CYCLES idle gap.
module sent_tx_scheduler
    import sent_pkg::*;
#(
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk_tx,
    input  logic        reset_n_tx,
    input  logic [1:0]  req_i,
    input  logic [1:0]  fmt_i,
    input  logic [1:0]  cfg_i,
    input  logic [7:0]  id_a_i,
    input  logic [15:0] data_a_i,
    input  logic [7:0]  id_b_i,
    input  logic [15:0] data_b_i,
    output logic [1:0]  ack_o,
    output logic [1:0]  done_o,
    input  logic        tx_idle_i,
    output logic        enable_o,
    output logic        channel_format_o,
    output logic        config_bit_o,
    output logic [7:0]  id_o,
    output logic [15:0] data_bit_field_o,
    output logic        busy_o,
    output logic        owner_o,
    output logic        timeout_o
);

    localparam int unsigned GAP_W = cnt_width(GAP_CYCLES);
    localparam int unsigned TO_W  = cnt_width(TIMEOUT_CYCLES);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);

`ifdef SENT_SCHED_FIXED_PRIO_EN
    localparam logic FIXED_PRIO = 1'b1;
`else
    localparam logic FIXED_PRIO = 1'b0;
`endif

    sched_state_t     state_q, state_d;
    sent_msg_t        msg_q, msg_d;
    logic             owner_q, owner_d;
    logic             last_owner_q, last_owner_d;
    logic             busy_q, busy_d;
    logic [1:0]       done_q, done_d;
    logic             timeout_q, timeout_d;
    logic             idle_prev_q;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

    logic [1:0]       gnt;
    logic             sel_b;
    logic             idle_edge;
    logic [TO_W-1:0]  to_inc;
    logic [GAP_W-1:0] gap_inc;

    sent_rr_arb2 u_arb (
        .req_i        (req_i),
        .last_owner_i (last_owner_q),
        .fixed_prio_i (FIXED_PRIO),
        .gnt_o        (gnt)
    );

    assign sel_b     = gnt[1];
    assign idle_edge = tx_idle_i & ~idle_prev_q;
    assign to_inc    = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1;
    assign gap_inc   = (gap_cnt_q == GAP_MAX) ? gap_cnt_q : gap_cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        msg_d        = msg_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        busy_d       = busy_q;
        done_d       = 2'b00;
        timeout_d    = timeout_q;
        to_cnt_d     = '0;
        gap_cnt_d    = '0;
        ack_o        = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (req_i != 2'b00) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (gnt != 2'b00) begin
                    ack_o        = gnt;
                    owner_d      = sel_b;
                    last_owner_d = sel_b;
                    msg_d.fmt    = fmt_i[sel_b];
                    msg_d.cfg    = cfg_i[sel_b];
                    msg_d.id     = sel_b ? id_b_i : id_a_i;
                    msg_d.data   = sel_b ? data_b_i : data_a_i;
                    busy_d       = 1'b1;
                    state_d      = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                // The timeout window opens with the enable pulse.
                to_cnt_d = to_inc;
                state_d  = ST_BUSY;
            end
            ST_BUSY: begin
                to_cnt_d = to_inc;
                if (idle_edge || (to_inc == TO_MAX)) begin
                    timeout_d = timeout_q | ~idle_edge;
                    done_d    = owner_q ? 2'b10 : 2'b01;
                    busy_d    = 1'b0;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_inc;
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_tx or negedge reset_n_tx) begin
        if (!reset_n_tx) begin
            state_q      <= ST_IDLE;
            msg_q        <= '{fmt: FMT_SERIAL, cfg: 1'b0, id: 8'h00, data: 16'h0000};
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 2'b00;
            timeout_q    <= 1'b0;
            idle_prev_q  <= 1'b0;
            to_cnt_q     <= '0;
            gap_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            msg_q        <= msg_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            idle_prev_q  <= tx_idle_i;
            to_cnt_q     <= to_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

    assign enable_o         = (state_q == ST_START);
    assign done_o           = done_q;
    assign busy_o           = busy_q;
    assign owner_o          = owner_q;
    assign timeout_o        = timeout_q;
    assign channel_format_o = msg_q.fmt;
    assign config_bit_o     = msg_q.cfg;
    assign id_o             = msg_q.id;
    assign data_bit_field_o = msg_q.data;

endmodule

// File: tb/tb_sent_tx_scheduler.sv
// Bench for sent_tx_scheduler: instance 0 with a 3-cycle gap, instance 1 with no gap, both 100-cycle timeout.
// Transaction-level model predicts grant, latched payload and ack/enable/done timing per message.
module tb_sent_tx_scheduler;

    localparam int TO   = 100;
    localparam int GAP0 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]  req_v [2];
    logic [1:0]  fmt_v [2];
    logic [1:0]  cfg_v [2];
    logic [7:0]  ida   [2];
    logic [15:0] da    [2];
    logic [7:0]  idb   [2];
    logic [15:0] db    [2];
    logic        txi   [2];

    logic [1:0]  ack_w  [2];
    logic [1:0]  done_w [2];
    logic        en_w   [2];
    logic        chf_w  [2];
    logic        cfgo_w [2];
    logic [7:0]  id_w   [2];
    logic [15:0] dat_w  [2];
    logic        busy_w [2];
    logic        own_w  [2];
    logic        tmo_w  [2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        sent_tx_scheduler #(
            .GAP_CYCLES     ((k == 0) ? GAP0 : 0),
            .TIMEOUT_CYCLES (TO)
        ) u_dut (
            .clk_tx           (clk),
            .reset_n_tx       (rst_n),
            .req_i            (req_v[k]),
            .fmt_i            (fmt_v[k]),
            .cfg_i            (cfg_v[k]),
            .id_a_i           (ida[k]),
            .data_a_i         (da[k]),
            .id_b_i           (idb[k]),
            .data_b_i         (db[k]),
            .ack_o            (ack_w[k]),
            .done_o           (done_w[k]),
            .tx_idle_i        (txi[k]),
            .enable_o         (en_w[k]),
            .channel_format_o (chf_w[k]),
            .config_bit_o     (cfgo_w[k]),
            .id_o             (id_w[k]),
            .data_bit_field_o (dat_w[k]),
            .busy_o           (busy_w[k]),
            .owner_o          (own_w[k]),
            .timeout_o        (tmo_w[k])
        );
    end

    int   checks = 0;
    int   fails  = 0;
    int   req_since [2];
    int   idle_from [2];
    logic last      [2];
    logic tmo_exp   [2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Gap between done and the cycle the scheduler is idle again.
    function automatic int gap_eff(input int k);
        return (k == 0) ? GAP0 : 1;
    endfunction

    function automatic logic [1:0] exp_grant(input logic [1:0] r, input logic lst);
`ifdef SENT_SCHED_FIXED_PRIO_EN
        if (r[0]) return 2'b01;
        return r[1] ? 2'b10 : 2'b00;
`else
        if (r == 2'b11) return lst ? 2'b01 : 2'b10;
        return r;
`endif
    endfunction

    function automatic logic [63:0] all_outs(input int k);
        logic [63:0] v;
        v = {30'd0, ack_w[k], done_w[k], en_w[k], chf_w[k], cfgo_w[k],
             id_w[k], dat_w[k], busy_w[k], own_w[k], tmo_w[k]};
        return v;
    endfunction

    task automatic new_payload(input int k);
        fmt_v[k] = 2'($urandom_range(0, 3));
        cfg_v[k] = 2'($urandom_range(0, 3));
        ida[k]   = 8'($urandom_range(0, 255));
        idb[k]   = 8'($urandom_range(0, 255));
        da[k]    = 16'($urandom_range(0, 65535));
        db[k]    = 16'($urandom_range(0, 65535));
    endtask

    // One message: raise request bits, expect ack/enable/done. lat = cycles the
    // transmitter stays busy after its idle flag drops; lat = 0 never finishes.
    task automatic do_msg(input int k, input logic [1:0] raise, input bit keep, input int lat);
        logic [1:0]  g;
        logic [25:0] exp_msg;
        int a_cyc, e_cyc, d_cyc, exp_d;
        @(posedge clk); #1;
        if (req_v[k] == 2'b00 && raise != 2'b00) req_since[k] = cyc;
        req_v[k] = req_v[k] | raise;
        a_cyc = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ack_w[k] != 2'b00) begin
                a_cyc = cyc;
                break;
            end
        end
        if (a_cyc < 0) begin
            check_eq("ack_seen", 0, 1);
            return;
        end
        g = exp_grant(req_v[k], last[k]);
        check_eq("ack_grant", ack_w[k], g);
        check_eq("ack_time", a_cyc, max2(req_since[k], idle_from[k]) + 1);
        exp_msg = g[1] ? {fmt_v[k][1], cfg_v[k][1], idb[k], db[k]}
                       : {fmt_v[k][0], cfg_v[k][0], ida[k], da[k]};
        last[k] = g[1];
        @(posedge clk); #1;
        if (!keep) req_v[k] = req_v[k] & ~g;
        new_payload(k);
        @(negedge clk);
        e_cyc = cyc;
        check_eq("enable", en_w[k], 1);
        check_eq("start_busy", busy_w[k], 1);
        check_eq("owner", own_w[k], g[1]);
        check_eq("latched_msg", {chf_w[k], cfgo_w[k], id_w[k], dat_w[k]}, exp_msg);
        exp_d = (lat == 0) ? e_cyc + TO : e_cyc + 2 + lat;
        if (lat == 0) tmo_exp[k] = 1'b1;
        d_cyc = -1;
        for (int j = 1; j <= 200; j++) begin
            @(posedge clk); #1;
            if (j == 1) txi[k] = 1'b0;
            if (lat > 0 && j == lat + 1) txi[k] = 1'b1;
            @(negedge clk);
            if (j == 1) check_eq("enable_pulse", en_w[k], 0);
            if (done_w[k] != 2'b00) begin
                d_cyc = cyc;
                break;
            end
        end
        if (d_cyc < 0) begin
            check_eq("done_seen", 0, 1);
            return;
        end
        check_eq("done_owner", done_w[k], g);
        check_eq("done_time", d_cyc, exp_d);
        check_eq("done_busy", busy_w[k], 0);
        check_eq("timeout_flag", tmo_w[k], tmo_exp[k]);
        check_eq("msg_stable", {chf_w[k], cfgo_w[k], id_w[k], dat_w[k]}, exp_msg);
        idle_from[k] = d_cyc + gap_eff(k);
        @(posedge clk); #1;
        if (lat == 0) txi[k] = 1'b1;
        @(negedge clk);
        check_eq("done_single", done_w[k], 0);
    endtask

    task automatic drain(input int k);
        for (int i = 0; i < 4 && req_v[k] != 2'b00; i++) begin
            do_msg(k, 2'b00, 1'b0, $urandom_range(1, 20));
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            req_v[k]     = 2'b00;
            txi[k]       = 1'b1;
            last[k]      = 1'b1;
            tmo_exp[k]   = 1'b0;
            req_since[k] = 0;
        end
    endtask

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int a_seen;
        rst_n = 1'b0;
        model_reset();
        new_payload(0);
        new_payload(1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outs0", all_outs(0), 0);
        check_eq("reset_outs1", all_outs(1), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_from[0] = cyc;
        idle_from[1] = cyc;

        // Single request from A with a known payload.
        ida[0] = 8'h5A; da[0] = 16'h0123; fmt_v[0] = 2'b01; cfg_v[0] = 2'b10;
        do_msg(0, 2'b01, 1'b0, 6);

        // Both requesting continuously.
        repeat (3) do_msg(0, 2'b11, 1'b1, $urandom_range(1, 30));
        drain(0);

        for (int n = 0; n < 14; n++) begin
            logic [1:0] r;
            if (req_v[0] == 2'b00) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                r = 2'($urandom_range(1, 3));
            end else begin
                r = 2'($urandom_range(0, 3));
            end
            do_msg(0, r, 1'b0, $urandom_range(1, 60));
        end
        drain(0);

        // Transmitter never returns idle; then an idle pulse while the scheduler is idle.
        do_msg(0, 2'b01, 1'b0, 0);
        repeat (GAP0 + 2) @(posedge clk);
        #1 txi[0] = 1'b0;
        @(posedge clk); #1;
        txi[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("spurious_done", done_w[0], 0);
            check_eq("spurious_busy", busy_w[0], 0);
        end
        do_msg(0, 2'b10, 1'b0, 5);
        do_msg(0, 2'b01, 1'b0, 4);

        // Reset while a message from A is in flight.
        @(posedge clk); #1;
        req_v[0] = 2'b01;
        a_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack_w[0] != 2'b00) begin
                a_seen = 1;
                break;
            end
        end
        check_eq("rst_pre_ack", a_seen, 1);
        @(posedge clk); #1;
        req_v[0] = 2'b00;
        repeat (3) @(posedge clk);
        #1 check_eq("rst_pre_busy", busy_w[0], 1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_outs0", all_outs(0), 0);
        check_eq("rst_mid_outs1", all_outs(1), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle_from[0] = cyc;
        idle_from[1] = cyc;
        do_msg(0, 2'b11, 1'b0, 4);
        drain(0);

        // Zero-gap instance: contention back to back, then random traffic.
        repeat (3) do_msg(1, 2'b11, 1'b1, $urandom_range(1, 20));
        drain(1);
        for (int n = 0; n < 6; n++) begin
            logic [1:0] r;
            r = (req_v[1] == 2'b00) ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
            do_msg(1, r, 1'b0, $urandom_range(1, 40));
        end
        drain(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/sent_tx_scheduler.md
SENT_TX_SCHEDULER -- requirements
Module: sent_tx_scheduler

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 16, giving the idle cycles enforced between consecutive messages.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535, giving the maximum cycles to wait for message completion.
REQ-003 SHALL use one clock and an asynchronous, active-low reset:
- clk_tx  in  1  clock
- reset_n_tx  in  1  asynchronous, active-low reset
REQ-004 SHALL have requester inputs:
- req_i  in  2  request per requester (bit 0 = A, bit 1 = B), level, held until ack
- fmt_i  in  2  channel format per requester (0 serial, 1 enhanced)
- cfg_i  in  2  config bit per requester
- id_a_i  in  8  message id, requester A
- data_a_i  in  16  message data, requester A
- id_b_i  in  8  message id, requester B
- data_b_i  in  16  message data, requester B
REQ-005 SHALL have requester outputs:
- ack_o  out  2  one-cycle accept pulse to the granted requester
- done_o  out  2  one-cycle completion pulse to the owning requester
REQ-006 SHALL have transmitter-side ports:
- tx_idle_i  in  1  idle flag from the SENT transmit controller
- enable_o  out  1  one-cycle start pulse
- channel_format_o  out  1  latched format
- config_bit_o  out  1  latched config bit
- id_o  out  8  latched id
- data_bit_field_o  out  16  latched data
REQ-007 SHALL have status outputs:
- busy_o  out  1  message in flight
- owner_o  out  1  current or last owner (0 = A)
- timeout_o  out  1  sticky timeout error

Function
REQ-008 SHALL implement states IDLE, ARB, START, BUSY and GAP.
REQ-009 In IDLE, SHALL move to ARB when req_i is nonzero.
REQ-010 In ARB, SHALL select one requester, latch its fmt/cfg/id/data onto the transmitter outputs, pulse the matching ack_o bit, set owner_o, and go to START, all in the same cycle.
REQ-011 Arbitration SHALL be round-robin: with both requesting, the requester other than the previous owner wins; after reset, A wins first.
REQ-012 In START, SHALL pulse enable_o for exactly one cycle, set busy_o, and go to BUSY.
REQ-013 In BUSY, SHALL detect the 0->1 edge of tx_idle_i (registered previous value), then pulse done_o[owner], clear busy_o, and go to GAP.
REQ-014 In BUSY, a cycle counter SHALL increment; on reaching TIMEOUT_CYCLES without the edge, SHALL set timeout_o, pulse done_o[owner], clear busy_o, and go to GAP.
REQ-015 In GAP, SHALL count GAP_CYCLES cycles, then return to IDLE; GAP_CYCLES = 0 SHALL return to IDLE on the next cycle.
REQ-016 SHALL ignore req_i changes outside IDLE and ARB; the latched message outputs SHALL stay stable from ARB until the next ARB.
REQ-017 SHALL ignore a tx_idle_i edge outside BUSY.
REQ-018 Once set, timeout_o SHALL clear only on reset.
REQ-019 Counters SHALL be sized ceil(log2(param+1)) bits and SHALL saturate, never wrap.
REQ-020 Minimum request-to-enable latency SHALL be 2 cycles (IDLE->ARB->START).

Reset
REQ-021 Asserting reset_n_tx low at any time, including mid-message, SHALL immediately force state IDLE, zero all outputs and counters, set the previous owner to B, and clear the idle-edge register.

Configuration
REQ-022 With SENT_SCHED_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (A always wins over B); without it, arbitration SHALL be round-robin per REQ-011.

Structure
REQ-023 The state encoding and the format constants (serial = 0, enhanced = 1) SHALL be defined in the shared sent_pkg.
REQ-024 The arbiter SHALL be a sub-module, sent_rr_arb2, taking req, last_owner and the macro-selected mode and returning a one-hot grant.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Single request: req_i = 01, id_a = 8'h5A, data_a = 16'h0123 -> ack_o = 01 next cycle; enable_o one cycle later with id_o = 5A, data_bit_field_o = 0123; done_o = 01 one cycle after tx_idle_i rises.
- Contention: req_i = 11 held continuously -> grants alternate A, B, A with GAP_CYCLES idle cycles between each done and the next ack; with the macro defined -> A, A, A.
- Timeout: TIMEOUT_CYCLES = 100, tx_idle_i held 0 -> timeout_o = 1 and done_o pulses 100 cycles after enable; scheduler returns to IDLE after the gap.
- Reset mid-BUSY: assert reset_n_tx during BUSY -> all outputs 0 immediately; first grant after release goes to A.
- Spurious idle: tx_idle_i pulses during GAP/IDLE -> no done_o pulse.
- GAP_CYCLES = 0 with back-to-back requests -> next ack 2 cycles after done_o.
